// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and CLKS_PER_BIT derivation used by the transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_e;
  function automatic int clks_per_bit(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: producer-to-transmitter bundle; master drives DIN/DIN_VALID, slave drives DIN_READY/TX/BUSY/LEVEL
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0] DIN;
  logic DIN_VALID;
  logic DIN_READY;
  logic TX;
  logic BUSY;
  logic [$clog2(FIFO_DEPTH):0] LEVEL;
  modport master (output DIN, DIN_VALID, input DIN_READY, TX, BUSY, LEVEL);
  modport slave (input DIN, DIN_VALID, output DIN_READY, TX, BUSY, LEVEL);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: register-based synchronous byte FIFO; clk/rst, push_i+din_i in, pop_i+dout_o out, full_o/empty_o/level_o status
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [7:0]             din_i,
  input  logic                   pop_i,
  output logic [7:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic push, pop;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign push = push_i && !full_o;
  assign pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with byte FIFO; CLK/RST plain, bus.slave carries DIN/DIN_VALID in and DIN_READY/TX/BUSY/LEVEL out
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int FIFO_DEPTH = 4
) (
  input logic      CLK,
  input logic      RST,
  uart_tx_if.slave bus
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, pop, full, empty, strobe;
  logic [LW-1:0] level;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .push_i (bus.DIN_VALID),
    .din_i  (bus.DIN),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );
  assign strobe = baud_q == BW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state_q;
    baud_d = strobe ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          bit_d = '0;
          state_d = START;
        end
      end
      START: state_d = strobe ? DATA : START;
      DATA: if (strobe) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (strobe) begin
        pop = !empty;
        shift_d = empty ? shift_q : head;
        bit_d = '0;
        state_d = empty ? IDLE : START;
      end
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
  assign bus.DIN_READY = !full;
  assign bus.TX = tx_q;
  assign bus.BUSY = state_q != IDLE || level != '0;
  assign bus.LEVEL = level;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and scoreboard-checked bench for uart_tx at CLKS_PER_BIT=4
module tb_uart_tx;
  localparam int CPB = 4;
  typedef struct packed {
    logic [7:0] din;
    logic [9:0] frame;
    logic [2:0] level;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int rx_frames = 0;
  bit rx_on = 1'b0;
  int rx_cnt = 0;
  int rx_bit = 0;
  logic [7:0] rx_byte = '0;
  always #5 CLK = ~CLK;
  uart_tx_if #(.FIFO_DEPTH(4)) bus ();
  uart_tx #(.BAUD_RATE(3000000), .CLOCK_FREQ_HZ(12000000), .FIFO_DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [39:0] wave_of(input logic [9:0] frame);
    logic [39:0] w;
    for (int j = 0; j < 40; j++) w[j] = frame[j / CPB];
    return w;
  endfunction
  always @(posedge CLK)
    if (!RST && bus.DIN_VALID && bus.DIN_READY) exp_q.push_back(bus.DIN);
  always @(negedge CLK) begin
    if (RST) begin
      rx_on = 1'b0;
      exp_q.delete();
    end else begin
      if (rx_on) rx_cnt++;
      else if (bus.TX === 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
      if (rx_on && rx_cnt % CPB == CPB / 2) begin
        rx_bit = rx_cnt / CPB;
        if (rx_bit == 0) chk("rx_start_bit", 64'(bus.TX), 64'd0);
        else if (rx_bit < 9) rx_byte[rx_bit-1] = bus.TX;
        else begin
          chk("rx_stop_bit", 64'(bus.TX), 64'd1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected_frame got %0h expected no frame", rx_byte);
          end else begin
            checks--;
            chk("rx_byte", 64'(rx_byte), 64'(exp_q.pop_front()));
          end
          rx_frames++;
          rx_on = 1'b0;
        end
      end
    end
  end
  task automatic drain(input int budget);
    int n = 0;
    while ((bus.BUSY || rx_on) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[5];
    logic [39:0] got, got2;
    int bad, n, maxlvl, frames0;
    bit acc, seen_full, seen_rise;
    vecs[0] = '{8'hA5, {1'b1, 8'hA5, 1'b0}, 3'd1};
    vecs[1] = '{8'h00, {1'b1, 8'h00, 1'b0}, 3'd1};
    vecs[2] = '{8'hFF, {1'b1, 8'hFF, 1'b0}, 3'd1};
    vecs[3] = '{8'h3C, {1'b1, 8'h3C, 1'b0}, 3'd1};
    vecs[4] = '{8'h81, {1'b1, 8'h81, 1'b0}, 3'd1};
    bus.DIN = 'x;
    bus.DIN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_tx", 64'(bus.TX), 64'd1);
    chk("reset_ready", 64'(bus.DIN_READY), 64'd1);
    chk("reset_busy", 64'(bus.BUSY), 64'd0);
    chk("reset_level", 64'(bus.LEVEL), 64'd0);
    RST = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0 || bus.LEVEL !== '0 || bus.DIN_READY !== 1'b1) bad++;
    end
    chk("idle_bad_cycles", 64'(bad), 64'd0);
    foreach (vecs[v]) begin
      @(negedge CLK);
      bus.DIN = vecs[v].din;
      bus.DIN_VALID = 1'b1;
      @(negedge CLK);
      bus.DIN_VALID = 1'b0;
      bus.DIN = 'x;
      chk("tx_high_before_start", 64'(bus.TX), 64'd1);
      chk("level_after_push", 64'(bus.LEVEL), 64'(vecs[v].level));
      for (int j = 0; j < 40; j++) begin
        @(negedge CLK);
        got[j] = bus.TX;
      end
      chk("frame_wave", 64'(got), 64'(wave_of(vecs[v].frame)));
      chk("busy_in_stop", 64'(bus.BUSY), 64'd1);
      @(negedge CLK);
      chk("busy_after_frame", 64'(bus.BUSY), 64'd0);
      drain(20);
    end
    @(negedge CLK);
    bus.DIN = 8'h55;
    bus.DIN_VALID = 1'b1;
    @(negedge CLK);
    bus.DIN = 8'h0F;
    @(negedge CLK);
    bus.DIN_VALID = 1'b0;
    bus.DIN = 'x;
    chk("b2b_level", 64'(bus.LEVEL), 64'd1);
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge CLK);
      if (j < 40) got[j] = bus.TX;
      else got2[j-40] = bus.TX;
    end
    chk("b2b_frame1", 64'(got), 64'(wave_of({1'b1, 8'h55, 1'b0})));
    chk("b2b_frame2", 64'(got2), 64'(wave_of({1'b1, 8'h0F, 1'b0})));
    drain(20);
    frames0 = rx_frames;
    n = 0;
    maxlvl = 0;
    seen_full = 1'b0;
    seen_rise = 1'b0;
    for (int c = 0; c < 2000 && n < 8; c++) begin
      @(negedge CLK);
      if (int'(bus.LEVEL) > maxlvl) maxlvl = int'(bus.LEVEL);
      if (!bus.DIN_READY && !seen_full) begin
        seen_full = 1'b1;
        chk("full_sent_count", 64'(n), 64'd5);
        chk("full_level", 64'(bus.LEVEL), 64'd4);
      end
      if (bus.DIN_READY && seen_full && !seen_rise) begin
        seen_rise = 1'b1;
        chk("ready_rise_level", 64'(bus.LEVEL), 64'd3);
      end
      bus.DIN = 8'(n);
      bus.DIN_VALID = 1'b1;
      acc = bus.DIN_READY;
      @(posedge CLK);
      if (acc) n++;
    end
    @(negedge CLK);
    bus.DIN_VALID = 1'b0;
    bus.DIN = 'x;
    chk("overflow_all_sent", 64'(n), 64'd8);
    chk("overflow_saw_full", 64'(seen_full), 64'd1);
    chk("overflow_max_level", 64'(maxlvl), 64'd4);
    drain(500);
    chk("overflow_frames", 64'(rx_frames - frames0), 64'd8);
    frames0 = rx_frames;
    @(negedge CLK);
    bus.DIN = 8'hFF;
    bus.DIN_VALID = 1'b1;
    @(negedge CLK);
    bus.DIN = 8'h11;
    @(negedge CLK);
    bus.DIN = 8'h22;
    @(negedge CLK);
    bus.DIN_VALID = 1'b0;
    bus.DIN = 'x;
    chk("rst_pre_level", 64'(bus.LEVEL), 64'd2);
    repeat (16) @(negedge CLK);
    chk("rst_pre_busy", 64'(bus.BUSY), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_tx", 64'(bus.TX), 64'd1);
    chk("rst_mid_level", 64'(bus.LEVEL), 64'd0);
    chk("rst_mid_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_mid_ready", 64'(bus.DIN_READY), 64'd1);
    @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge CLK);
      if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0) bad++;
    end
    chk("rst_quiet_cycles", 64'(bad), 64'd0);
    chk("rst_no_frames", 64'(rx_frames - frames0), 64'd0);
    chk("rst_scoreboard_cleared", 64'(exp_q.size()), 64'd0);
    frames0 = rx_frames;
    @(negedge CLK);
    bus.DIN = 8'hC3;
    bus.DIN_VALID = 1'b1;
    @(negedge CLK);
    bus.DIN = 8'h5A;
    @(negedge CLK);
    bus.DIN = 8'h96;
    @(negedge CLK);
    bus.DIN_VALID = 1'b0;
    bus.DIN = 'x;
    repeat (38) @(negedge CLK);
    chk("sim_pre_level", 64'(bus.LEVEL), 64'd2);
    chk("sim_stop_tx", 64'(bus.TX), 64'd1);
    bus.DIN = 8'h7E;
    bus.DIN_VALID = 1'b1;
    @(negedge CLK);
    bus.DIN_VALID = 1'b0;
    bus.DIN = 'x;
    chk("sim_post_level", 64'(bus.LEVEL), 64'd2);
    chk("sim_start_tx", 64'(bus.TX), 64'd0);
    drain(300);
    chk("sim_frames", 64'(rx_frames - frames0), 64'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
